// File: rtl/dht11_pkg.sv
// Shared state encoding, frame layout and timing constants for the DHT11 sensor emulator.
package dht11_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHostLow,
        StHostRel,
        StRespLow,
        StRespHigh,
        StBitLow,
        StBitHigh,
        StEndLow
    } dht11_state_e;

    localparam int unsigned HOST_REL_US  = 30;
    localparam int unsigned RESP_LOW_US  = 80;
    localparam int unsigned RESP_HIGH_US = 80;
    localparam int unsigned BIT_LOW_US   = 50;
    localparam int unsigned BIT0_HIGH_US = 26;
    localparam int unsigned BIT1_HIGH_US = 70;
    localparam int unsigned END_LOW_US   = 50;
    localparam int unsigned FRAME_BITS   = 40;

    function automatic logic [7:0] checksum(input logic [7:0] hum, input logic [7:0] temp);
        return hum + temp;
    endfunction

    // Wire order is MSB first: humidity, 0x00, temperature, 0x00, checksum.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] hum,
                                                         input logic [7:0] temp,
                                                         input logic [7:0] chk);
        return {hum, 8'h00, temp, 8'h00, chk};
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// Free-running prescaler producing a one-cycle strobe every microsecond of system clock.
module dht11_us_tick #(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic us_tick_o
);

    localparam int unsigned DIV  = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign us_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/dht11_emu.sv
// DHT11 sensor emulator: answers a host start pulse on the single-wire bus with a 40-bit frame.
module dht11_emu
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned START_MIN_US = 18000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_i,
    output logic       data_oe,
    input  logic [7:0] humidity,
    input  logic [7:0] temperature,
    output logic       busy,
    output logic       frame_done
);

    // One spare bit above the start threshold so saturation can never alias below it.
    localparam int unsigned CNT_W = (START_MIN_US >= 128) ? $clog2(START_MIN_US + 1) + 1 : 8;

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [CNT_W-1:0] START_MIN     = CNT_W'(START_MIN_US);
    localparam logic [CNT_W-1:0] HOST_REL_LAST = CNT_W'(HOST_REL_US - 1);
    localparam logic [CNT_W-1:0] RESP_LO_LAST  = CNT_W'(RESP_LOW_US - 1);
    localparam logic [CNT_W-1:0] RESP_HI_LAST  = CNT_W'(RESP_HIGH_US - 1);
    localparam logic [CNT_W-1:0] BIT_LOW_LAST  = CNT_W'(BIT_LOW_US - 1);
    localparam logic [CNT_W-1:0] BIT0_LAST     = CNT_W'(BIT0_HIGH_US - 1);
    localparam logic [CNT_W-1:0] BIT1_LAST     = CNT_W'(BIT1_HIGH_US - 1);
    localparam logic [CNT_W-1:0] END_LOW_LAST  = CNT_W'(END_LOW_US - 1);
    localparam logic [5:0]       LAST_BIT      = 6'(FRAME_BITS - 1);

    dht11_state_e state_q, state_d;

    logic [1:0]            sync_q;
    logic                  prev_q;
    logic                  level;
    logic                  rise;
    logic                  fall;
    logic                  us_tick;
    logic [CNT_W-1:0]      us_cnt_q, us_cnt_d;
    logic [CNT_W-1:0]      dur_last;
    logic                  timed;
    logic                  step;
    logic [5:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [7:0]            hum_q, hum_d;
    logic [7:0]            temp_q, temp_d;
    logic [7:0]            chk_q, chk_d;
    logic                  oe_q, oe_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    dht11_us_tick #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_us_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .us_tick_o(us_tick)
    );

    assign level = sync_q[1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

    always_comb begin
        dur_last = '0;
        unique case (state_q)
            StHostRel:  dur_last = HOST_REL_LAST;
            StRespLow:  dur_last = RESP_LO_LAST;
            StRespHigh: dur_last = RESP_HI_LAST;
            StBitLow:   dur_last = BIT_LOW_LAST;
            StBitHigh:  dur_last = shift_q[FRAME_BITS-1] ? BIT1_LAST : BIT0_LAST;
            StEndLow:   dur_last = END_LOW_LAST;
            default:    dur_last = '0;
        endcase
    end

    assign timed = (state_q != StIdle) && (state_q != StHostLow);
    assign step  = timed && us_tick && (us_cnt_q == dur_last);

    always_comb begin
        state_d   = state_q;
        us_cnt_d  = us_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        hum_d     = hum_q;
        temp_d    = temp_q;
        chk_d     = chk_q;

        if (timed && us_tick) begin
            us_cnt_d = step ? '0 : us_cnt_q + CNT_ONE;
        end

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d  = StHostLow;
                    us_cnt_d = '0;
                end
            end
            StHostLow: begin
                if (us_tick && (us_cnt_q != CNT_MAX)) begin
                    us_cnt_d = us_cnt_q + CNT_ONE;
                end
                if (rise) begin
                    us_cnt_d = '0;
                    if (us_cnt_q >= START_MIN) begin
                        state_d = StHostRel;
                        hum_d   = humidity;
                        temp_d  = temperature;
                        chk_d   = checksum(humidity, temperature);
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHostRel: begin
                if (step) begin
                    state_d = StRespLow;
                    shift_d = frame_word(hum_q, temp_q, chk_q);
                end
            end
            StRespLow: begin
                if (step) state_d = StRespHigh;
            end
            StRespHigh: begin
                if (step) begin
                    state_d   = StBitLow;
                    bit_idx_d = '0;
                end
            end
            StBitLow: begin
                if (step) state_d = StBitHigh;
            end
            StBitHigh: begin
                if (step) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = StEndLow;
                    end else begin
                        state_d   = StBitLow;
                        bit_idx_d = bit_idx_q + 6'd1;
                        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            StEndLow: begin
                if (step) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so the bus drive changes cleanly on the edge.
    always_comb begin
        oe_d   = (state_d == StRespLow) || (state_d == StBitLow) || (state_d == StEndLow);
        busy_d = (state_d != StIdle) && (state_d != StHostLow);
        done_d = (state_q == StEndLow) && (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            prev_q    <= 1'b1;
            us_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            hum_q     <= '0;
            temp_q    <= '0;
            chk_q     <= '0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], data_i};
            prev_q    <= level;
            us_cnt_q  <= us_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            hum_q     <= hum_d;
            temp_q    <= temp_d;
            chk_q     <= chk_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign data_oe    = oe_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_dht11_emu.sv
// Directed bench for dht11_emu: 2 MHz clock (2 clocks per us) and a 200 us start threshold.
module tb_dht11_emu;

    localparam int unsigned CLK_HZ   = 2_000_000;
    localparam int unsigned START_US = 200;
    localparam int          CPU      = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_low = 1'b0;
    logic [7:0] humidity = 8'h00;
    logic [7:0] temperature = 8'h00;
    logic       data_i;
    logic       data_oe;
    logic       busy;
    logic       frame_done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cur_bit = -1;

    typedef struct {
        logic [39:0] bits;
        int          rlow;
        int          rhigh;
        int          elow;
        int          l_min;
        int          l_max;
        int          z_min;
        int          z_max;
        int          o_min;
        int          o_max;
        logic        busy_seen;
        bit          to;
    } frame_t;

    // Open-drain bus with pull-up: low if either side pulls.
    assign data_i = ~(host_low | data_oe);

    dht11_emu #(
        .CLK_FREQ_HZ (CLK_HZ),
        .START_MIN_US(START_US)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .data_oe    (data_oe),
        .humidity   (humidity),
        .temperature(temperature),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic host_req(input int us);
        @(negedge clk);
        host_low = 1'b1;
        repeat (us * CPU) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic measure(input logic lvl, output int n, output bit t);
        n = 0;
        t = 1'b0;
        while (data_oe === lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) t = 1'b1;
    endtask

    task automatic capture(output frame_t f);
        int  n;
        int  k;
        bit  t;
        f = '{default: 0};
        f.l_min = 9999;
        f.z_min = 9999;
        f.o_min = 9999;
        cur_bit = -1;
        k = 0;
        while (data_oe !== 1'b1 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 4000) f.to = 1'b1;
        f.busy_seen = busy;
        measure(1'b1, f.rlow, t);  f.to |= t;
        measure(1'b0, f.rhigh, t); f.to |= t;
        for (int i = 0; i < 40; i++) begin
            cur_bit = i;
            measure(1'b1, n, t); f.to |= t;
            if (n < f.l_min) f.l_min = n;
            if (n > f.l_max) f.l_max = n;
            measure(1'b0, n, t); f.to |= t;
            f.bits = {f.bits[38:0], (n > 96)};
            if (n > 96) begin
                if (n < f.o_min) f.o_min = n;
                if (n > f.o_max) f.o_max = n;
            end else begin
                if (n < f.z_min) f.z_min = n;
                if (n > f.z_max) f.z_max = n;
            end
        end
        measure(1'b1, f.elow, t); f.to |= t;
        cur_bit = 40;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", data_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (data_oe !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: oe=%b busy=%b want 0/0", data_oe, busy);
        end
    endtask

    task automatic test_basic;
        frame_t f;
        int     d0;
        humidity = 8'h37; temperature = 8'h19;
        d0 = done_cnt;
        host_req(250);
        capture(f);
        repeat (5) @(negedge clk);
        checks++; if (f.to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b want 0", f.to); end
        checks++; if (f.busy_seen !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", f.busy_seen); end
        checks++; if (f.bits !== 40'h3700190050) begin errors++; $display("FAIL basic_bits: got %h want 3700190050", f.bits); end
        checks++; if (f.rlow < 158 || f.rlow > 162) begin errors++; $display("FAIL basic_resp_low: got %0d cycles want 160", f.rlow); end
        checks++; if (f.rhigh < 158 || f.rhigh > 162) begin errors++; $display("FAIL basic_resp_high: got %0d cycles want 160", f.rhigh); end
        checks++; if (f.elow < 98 || f.elow > 102) begin errors++; $display("FAIL basic_end_low: got %0d cycles want 100", f.elow); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_short_pulse;
        int d0;
        bit oe_seen;
        bit busy_seen;
        d0 = done_cnt;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        fork
            host_req(150);
            for (int k = 0; k < 1200; k++) begin
                @(negedge clk);
                if (data_oe === 1'b1) oe_seen = 1'b1;
                if (busy === 1'b1) busy_seen = 1'b1;
            end
        join
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL short_oe: got %b want 0", oe_seen); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL short_busy: got %b want 0", busy_seen); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL short_done: got %0d want %0d", done_cnt, d0); end
    endtask

    task automatic test_checksum;
        frame_t f;
        humidity = 8'hFF; temperature = 8'h02;
        host_req(250);
        capture(f);
        repeat (5) @(negedge clk);
        checks++; if (f.bits !== 40'hFF00020001) begin errors++; $display("FAIL cksum_bits: got %h want ff00020001", f.bits); end
        checks++; if (f.o_min < 138 || f.o_max > 142) begin
            errors++; $display("FAIL cksum_one_width: got %0d..%0d cycles want 140", f.o_min, f.o_max);
        end
        checks++; if (f.z_min < 50 || f.z_max > 54) begin
            errors++; $display("FAIL cksum_zero_width: got %0d..%0d cycles want 52", f.z_min, f.z_max);
        end
        checks++; if (f.l_min < 98 || f.l_max > 102) begin
            errors++; $display("FAIL cksum_bit_low: got %0d..%0d cycles want 100", f.l_min, f.l_max);
        end
    endtask

    task automatic test_latch_ignore;
        frame_t f;
        int     d0;
        bit     oe_seen;
        humidity = 8'hA5; temperature = 8'h3C;
        d0 = done_cnt;
        host_req(250);
        fork
            capture(f);
            begin
                for (int k = 0; k < 20000 && cur_bit < 10; k++) @(negedge clk);
                humidity = 8'h00; temperature = 8'h00;
                for (int k = 0; k < 20000 && cur_bit < 15; k++) @(negedge clk);
                host_low = 1'b1;
                repeat (300 * CPU) @(negedge clk);
                host_low = 1'b0;
            end
        join
        oe_seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (data_oe === 1'b1) oe_seen = 1'b1;
        end
        checks++; if (f.to !== 1'b0) begin errors++; $display("FAIL latch_timeout: got %b want 0", f.to); end
        checks++; if (f.bits !== 40'hA5003C00E1) begin errors++; $display("FAIL latch_bits: got %h want a5003c00e1", f.bits); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL latch_done: got %0d want 1", done_cnt - d0); end
        checks++; if (oe_seen !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL latch_no_restart: oe_seen=%b busy=%b want 0/0", oe_seen, busy);
        end
    endtask

    task automatic test_reset_mid;
        frame_t f;
        int     d0;
        int     rises;
        int     cyc;
        logic   prev;
        bit     oe_seen;
        humidity = 8'h55; temperature = 8'h0A;
        host_req(250);
        rises = 0;
        cyc = 0;
        prev = data_oe;
        while (rises < 22 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (data_oe === 1'b1 && prev !== 1'b1) rises++;
            prev = data_oe;
        end
        repeat (10) @(negedge clk);
        checks++; if (data_oe !== 1'b1) begin errors++; $display("FAIL mid_oe_before: got %b want 1", data_oe); end
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL mid_oe_reset: got %b want 0", data_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        oe_seen = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (data_oe === 1'b1) oe_seen = 1'b1;
        end
        checks++; if (oe_seen !== 1'b0 || done_cnt != d0) begin
            errors++; $display("FAIL mid_no_resume: oe_seen=%b done=%0d want 0/%0d", oe_seen, done_cnt, d0);
        end
        humidity = 8'h12; temperature = 8'h34;
        host_req(250);
        capture(f);
        repeat (5) @(negedge clk);
        checks++; if (f.bits !== 40'h1200340046 || f.to !== 1'b0) begin
            errors++; $display("FAIL mid_next_frame: got %h to=%b want 1200340046", f.bits, f.to);
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL mid_next_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back;
        frame_t f1;
        frame_t f2;
        int     d0;
        d0 = done_cnt;
        humidity = 8'h01; temperature = 8'h80;
        host_req(250);
        capture(f1);
        repeat (50 * CPU) @(negedge clk);
        humidity = 8'hC8; temperature = 8'h64;
        host_req(250);
        capture(f2);
        repeat (5) @(negedge clk);
        checks++; if (f1.bits !== 40'h0100800081 || f1.to !== 1'b0) begin
            errors++; $display("FAIL b2b_first: got %h to=%b want 0100800081", f1.bits, f1.to);
        end
        checks++; if (f2.bits !== 40'hC80064002C || f2.to !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got %h to=%b want c80064002c", f2.bits, f2.to);
        end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_pulse();
        test_checksum();
        test_latch_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
